parity_frame_tx: RTL and testbench
==================================

// Module: parity_frame_tx
// PURPOSE
//  Serial frame transmitter. Sits directly downstream of the nibble parity generator.
//  Accepts a DATA_W-bit word over a valid/ready handshake and computes its parity bit internally.
//  Shifts out one frame: start bit (0), data bits LSB first, parity bit, stop bit (1).
//  Drives the chip-level serial line. Even/odd parity is selected per word.
// PARAMETERS
//  DATA_W        4   data bits per frame (>=1)
//  CLKS_PER_BIT  4   clk cycles each serial bit is held on tx_serial (>=1)
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  in_data     in   DATA_W  word to send; sampled on handshake
//  in_valid    in   1       upstream word valid
//  odd_sel     in   1       sampled with in_data: 1 = odd parity, 0 = even parity
//  in_ready    out  1       block can accept a word this cycle
//  tx_serial   out  1       serial line, idles high; registered
//  busy        out  1       frame in progress (state != IDLE)
//  frame_done  out  1       one-cycle pulse on last cycle of stop bit
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, tx_serial=1, busy=0, frame_done=0.
//   Bit and baud counters are cleared. Captured word and parity are don't-care.
//  Reset mid-frame: the frame is abandoned and the line returns high the next cycle.
//   The aborted frame is never resumed.
//  in_ready = (state==IDLE) & ~rst. It is combinational from state only, never from in_valid.
//  Handshake: transfer when in_valid & in_ready at a rising edge.
//   On that edge: in_data and odd_sel are latched, state goes to START, tx_serial is driven to 0.
//   in_valid while busy is ignored. Upstream must hold the word until accepted.
//  Parity bit p = ^in_data ^ odd_sel.
//   Even mode (odd_sel=0): the total count of 1s in data+p is even.
//   Odd mode (odd_sel=1): the total count of 1s in data+p is odd.
//  FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   Each of START, PARITY and STOP lasts exactly CLKS_PER_BIT cycles.
//   DATA lasts DATA_W*CLKS_PER_BIT cycles. Bit i is driven during the i-th CLKS_PER_BIT window, i=0 first.
//  Baud counter counts 0..CLKS_PER_BIT-1. It wraps to 0 on each bit boundary and advances the bit/state.
//   The bit index wraps after bit DATA_W-1 and moves the FSM to PARITY.
//  Frame length: (DATA_W+3)*CLKS_PER_BIT cycles of tx_serial after the handshake edge.
//  frame_done is high on the final STOP cycle. The next edge returns to IDLE, tx_serial=1.
//  Back-to-back: in_ready rises the cycle after frame_done. The minimum gap between frames is one idle-high cycle.
//  busy=1 from the handshake edge until the edge that re-enters IDLE.
//  tx_serial is glitch-free: it is a flop output, with no combinational path to the output.
// TESTING
//  T1 reset: hold rst 3 cycles mid-idle -> tx_serial=1, busy=0, in_ready=1 after release, frame_done=0.
//  T2 even: in_data=4'b1011, odd_sel=0, defaults -> line sequence 0,1,1,0,1,1,1 (each bit 4 clk).
//   Expect 28 cycles busy and a frame_done pulse on cycle 28.
//  T3 odd: in_data=4'b1011, odd_sel=1 -> parity bit 0.
//   Also in_data=4'b0000, odd_sel=1 -> parity bit 1. Data bits all 0.
//  T4 stall: assert in_valid with a new word during T2's frame -> ignored, in_ready=0.
//   The word is accepted exactly 1 cycle after frame_done. The second frame follows one idle-high cycle.
//  T5 reset mid-frame: rst at cycle 10 of a frame -> tx_serial=1 next cycle, no frame_done.
//   A new word is accepted immediately after rst deasserts.
//  T6 param sweep: DATA_W=8, CLKS_PER_BIT=1, in_data=8'hA5, even -> 11-cycle frame.
//   Parity bit 0. Compare against a reference model bit-by-bit.

Source files
------------

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serial frame transmitter.
// Frame: start(0), data LSB first, parity, stop(1).
module parity_frame_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              odd_sel,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX =
    IW'(DATA_W - 1);
  localparam logic ONE_CLK =
    (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [BW-1:0]     baud_cnt;
  logic [BW-1:0]     baud_inc;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              baud_end;
  logic              last_bit;
  logic              take;

  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);
  assign take     = in_valid & in_ready;
  assign baud_inc = baud_cnt + 1'b1;
  assign baud_end = (baud_cnt == BAUD_MAX);
  assign last_bit = (bit_idx == IDX_MAX);

  // Frame FSM: baud pacing, bit shifting, registered line and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_serial  <= 1'b1;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (take) begin
            state     <= START;
            tx_serial <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_q   <= in_data;
            par_q     <= (^in_data) ^ odd_sel;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            tx_serial <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end else begin
            baud_cnt <= baud_inc;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (last_bit) begin
              bit_idx   <= '0;
              state     <= PARITY;
              tx_serial <= par_q;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_cnt <= baud_inc;
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud_cnt   <= '0;
            state      <= STOP;
            tx_serial  <= 1'b1;
            // a one-cycle stop bit is also its last cycle
            frame_done <= ONE_CLK;
          end else begin
            baud_cnt <= baud_inc;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            state     <= IDLE;
            tx_serial <= 1'b1;
          end else begin
            baud_cnt   <= baud_inc;
            frame_done <= (baud_inc == BAUD_MAX);
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          baud_cnt  <= '0;
          bit_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: directed + random frames
// against a frame-list reference model.
module tb_parity_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] a_data;
  logic       a_valid, a_odd;
  logic       a_ready, a_tx, a_busy, a_done;
  logic [7:0] b_data;
  logic       b_valid, b_odd;
  logic       b_ready, b_tx, b_busy, b_done;

  parity_frame_tx #(
    .DATA_W(4), .CLKS_PER_BIT(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_data), .in_valid(a_valid),
    .odd_sel(a_odd), .in_ready(a_ready),
    .tx_serial(a_tx), .busy(a_busy),
    .frame_done(a_done)
  );

  parity_frame_tx #(
    .DATA_W(8), .CLKS_PER_BIT(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_data), .in_valid(b_valid),
    .odd_sel(b_odd), .in_ready(b_ready),
    .tx_serial(b_tx), .busy(b_busy),
    .frame_done(b_done)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [15:0] seq;
  int          bn;

  // Frame as a list of bits: start, data LSB first, parity, stop.
  function automatic logic ref_bit(
    input logic [7:0] d, input logic odd,
    input int dw, input int k);
    logic q[$];
    int   ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    q.push_back(logic'((ones + int'(odd)) % 2));
    q.push_back(1'b1);
    return q[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
        tag, obs, exp);
    end
  endtask

  task automatic frame_a(
    input logic [3:0] d, input logic odd,
    input bit stall,
    input logic [3:0] d2, input logic odd2,
    output logic [15:0] sq, output int bc);
    a_data  = d;
    a_odd   = odd;
    a_valid = 1'b1;
    #1;
    check("a_ready_pre", 32'(a_ready), 32'd1);
    tick();
    if (stall) begin
      a_data  = d2;
      a_odd   = odd2;
      a_valid = 1'b1;
    end else begin
      a_valid = 1'b0;
    end
    sq = '0;
    bc = 0;
    for (int c = 1; c <= 28; c++) begin
      logic e;
      e = ref_bit({4'b0, d}, odd, 4, (c - 1) / 4);
      check("a_tx", 32'(a_tx), 32'(e));
      check("a_done", 32'(a_done), 32'(c == 28));
      check("a_ready_busy", 32'(a_ready), 32'd0);
      if ((c - 1) % 4 == 0)
        sq[(c - 1) / 4] = a_tx;
      if (a_busy) bc++;
      tick();
    end
    check("a_gap_tx", 32'(a_tx), 32'd1);
    check("a_gap_busy", 32'(a_busy), 32'd0);
    check("a_gap_ready", 32'(a_ready), 32'd1);
    check("a_gap_done", 32'(a_done), 32'd0);
  endtask

  task automatic frame_b(
    input logic [7:0] d, input logic odd,
    output logic [15:0] sq, output int bc);
    b_data  = d;
    b_odd   = odd;
    b_valid = 1'b1;
    #1;
    check("b_ready_pre", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    sq = '0;
    bc = 0;
    for (int c = 1; c <= 11; c++) begin
      logic e;
      e = ref_bit(d, odd, 8, c - 1);
      check("b_tx", 32'(b_tx), 32'(e));
      check("b_done", 32'(b_done), 32'(c == 11));
      sq[c - 1] = b_tx;
      if (b_busy) bc++;
      tick();
    end
    check("b_gap_tx", 32'(b_tx), 32'd1);
    check("b_gap_busy", 32'(b_busy), 32'd0);
    check("b_gap_ready", 32'(b_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] d, nd;
    logic       o, no;
    bit         st;

    rst     = 1'b1;
    a_data  = '0;
    a_valid = 1'b0;
    a_odd   = 1'b0;
    b_data  = '0;
    b_valid = 1'b0;
    b_odd   = 1'b0;

    // T1 reset
    repeat (3) tick();
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_b_tx", 32'(b_tx), 32'd1);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(a_ready), 32'd1);
    check("rel_b_ready", 32'(b_ready), 32'd1);
    tick();

    // T2 even frame with T4 stalled word
    frame_a(4'b1011, 1'b0, 1'b1,
      4'b0101, 1'b1, seq, bn);
    check("t2_seq", 32'(seq[6:0]), 32'h76);
    check("t2_busy", 32'(bn), 32'd28);
    frame_a(4'b0101, 1'b1, 1'b0,
      4'b0000, 1'b0, seq, bn);
    check("t4_data", 32'(seq[4:1]), 32'h5);

    // T3 odd parity
    frame_a(4'b1011, 1'b1, 1'b0,
      4'b0000, 1'b0, seq, bn);
    check("t3_par0", 32'(seq[5]), 32'd0);
    frame_a(4'b0000, 1'b1, 1'b0,
      4'b0000, 1'b0, seq, bn);
    check("t3_par1", 32'(seq[5]), 32'd1);
    check("t3_zero", 32'(seq[4:1]), 32'd0);

    // T5 reset mid-frame
    a_data  = 4'b0110;
    a_odd   = 1'b0;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    repeat (8) tick();
    check("t5_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_tx", 32'(a_tx), 32'd1);
    check("t5_busy0", 32'(a_busy), 32'd0);
    check("t5_done", 32'(a_done), 32'd0);
    check("t5_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    frame_a(4'b1001, 1'b0, 1'b0,
      4'b0000, 1'b0, seq, bn);

    // T6 DATA_W=8, CLKS_PER_BIT=1
    frame_b(8'hA5, 1'b0, seq, bn);
    check("t6_seq", 32'(seq[10:0]), 32'h54A);
    check("t6_par", 32'(seq[9]), 32'd0);
    check("t6_busy", 32'(bn), 32'd11);

    // random frames, optional stall and idle gaps
    d = 4'($urandom);
    o = 1'($urandom);
    for (int n = 0; n < 20; n++) begin
      nd = 4'($urandom);
      no = 1'($urandom);
      st = 1'($urandom_range(0, 1));
      frame_a(d, o, st, nd, no, seq, bn);
      check("r_busy", 32'(bn), 32'd28);
      if (!st) repeat ($urandom_range(0, 2)) tick();
      d = nd;
      o = no;
    end
    for (int n = 0; n < 20; n++) begin
      frame_b(8'($urandom), 1'($urandom), seq, bn);
      check("rb_busy", 32'(bn), 32'd11);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
